// File: rtl/chan_link_sequencer.sv
// Aurora channel bring-up sequencer: pulses the transceiver and core resets,
// waits for PLL lock and channel/lane up, retries on timeout or link drop,
// and gives up (FAIL) after a bounded number of re-attempts.
// All outputs are registered; the current FSM state is visible on 'state'.
module chan_link_sequencer #(
    parameter int RST_CYCLES = 128,
    parameter int UP_TIMEOUT = 1000000,
    parameter int MAX_RETRY  = 7
) (
    input  logic        io_clk,
    input  logic        io_reset_n,
    input  logic        enable,
    input  logic        clr_counts,
    input  logic        pll_not_locked,
    input  logic        lane_up,
    input  logic        channel_up,
    input  logic        hard_err,
    input  logic        soft_err,
    output logic        gt_reset,
    output logic        aurora_reset,
    output logic        link_ok,
    output logic        link_fail,
    output logic [2:0]  state,
    output logic [3:0]  retry_cnt,
    output logic [15:0] soft_err_cnt,
    output logic [15:0] hard_err_cnt
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RESET    = 3'd1,
        S_WAIT_PLL = 3'd2,
        S_WAIT_UP  = 3'd3,
        S_UP       = 3'd4,
        S_FAIL     = 3'd5
    } state_t;

    localparam logic [23:0] RST_LOAD  = 24'(RST_CYCLES - 1);
    localparam logic [23:0] UP_LOAD   = 24'(UP_TIMEOUT - 1);
    localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRY);

    state_t      state_q;
    state_t      state_n;
    logic [23:0] timer_q;
    logic [23:0] timer_n;
    logic [3:0]  retry_n;
    logic        retry_now;

    assign state = state_q;

    // Next-state, timer and retry-count decode; enable=0 overrides everything.
    always_comb begin
        state_n   = state_q;
        timer_n   = timer_q;
        retry_n   = retry_cnt;
        retry_now = 1'b0;
        if (!enable) begin
            state_n = S_IDLE;
            timer_n = 24'd0;
            retry_n = 4'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_n = S_RESET;
                    timer_n = RST_LOAD;
                end
                S_RESET: begin
                    if (timer_q == 24'd0) begin
                        state_n = S_WAIT_PLL;
                        timer_n = UP_LOAD;
                    end else begin
                        timer_n = timer_q - 24'd1;
                    end
                end
                S_WAIT_PLL: begin
                    if (!pll_not_locked) begin
                        state_n = S_WAIT_UP;
                        timer_n = UP_LOAD;
                    end else if (timer_q == 24'd0) begin
                        retry_now = 1'b1;
                    end else begin
                        timer_n = timer_q - 24'd1;
                    end
                end
                S_WAIT_UP: begin
                    // The up-condition wins over a coincident timeout.
                    if (channel_up && lane_up) begin
                        state_n = S_UP;
                    end else if (timer_q == 24'd0) begin
                        retry_now = 1'b1;
                    end else begin
                        timer_n = timer_q - 24'd1;
                    end
                end
                S_UP: begin
                    if (hard_err || !channel_up || !lane_up) begin
                        retry_now = 1'b1;
                    end
                end
                S_FAIL: begin
                    state_n = S_FAIL;
                end
                default: begin
                    state_n = S_IDLE;
                    timer_n = 24'd0;
                    retry_n = 4'd0;
                end
            endcase
            // Retry decision happens in the transition cycle, not as a state.
            if (retry_now) begin
                if (retry_cnt >= RETRY_MAX) begin
                    state_n = S_FAIL;
                    timer_n = 24'd0;
                end else begin
                    state_n = S_RESET;
                    timer_n = RST_LOAD;
                    retry_n = retry_cnt + 4'd1;
                end
            end
        end
    end

    // State, timer and retry count; clr_counts beats an increment.
    always_ff @(posedge io_clk) begin
        if (!io_reset_n) begin
            state_q   <= S_IDLE;
            timer_q   <= 24'd0;
            retry_cnt <= 4'd0;
        end else begin
            state_q   <= state_n;
            timer_q   <= timer_n;
            retry_cnt <= clr_counts ? 4'd0 : retry_n;
        end
    end

    // Registered reset/status outputs decoded from the next state so they line up with 'state'.
    always_ff @(posedge io_clk) begin
        if (!io_reset_n) begin
            gt_reset     <= 1'b1;
            aurora_reset <= 1'b1;
            link_ok      <= 1'b0;
            link_fail    <= 1'b0;
        end else begin
            gt_reset     <= (state_n == S_IDLE) || (state_n == S_RESET) || (state_n == S_FAIL);
            aurora_reset <= (state_n != S_WAIT_UP) && (state_n != S_UP);
            link_ok      <= (state_n == S_UP);
            link_fail    <= (state_n == S_FAIL);
        end
    end

    // Saturating error counters, counting only while the link is up.
    always_ff @(posedge io_clk) begin
        if (!io_reset_n) begin
            soft_err_cnt <= 16'd0;
            hard_err_cnt <= 16'd0;
        end else if (clr_counts) begin
            soft_err_cnt <= 16'd0;
            hard_err_cnt <= 16'd0;
        end else if (state_q == S_UP) begin
            if (soft_err && (soft_err_cnt != 16'hFFFF)) soft_err_cnt <= soft_err_cnt + 16'd1;
            if (hard_err && (hard_err_cnt != 16'hFFFF)) hard_err_cnt <= hard_err_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_chan_link_sequencer.sv
// Directed bench for chan_link_sequencer with RST_CYCLES=4, UP_TIMEOUT=16, MAX_RETRY=2.
module tb_chan_link_sequencer;

    logic        io_clk;
    logic        io_reset_n;
    logic        enable;
    logic        clr_counts;
    logic        pll_not_locked;
    logic        lane_up;
    logic        channel_up;
    logic        hard_err;
    logic        soft_err;
    logic        gt_reset;
    logic        aurora_reset;
    logic        link_ok;
    logic        link_fail;
    logic [2:0]  state;
    logic [3:0]  retry_cnt;
    logic [15:0] soft_err_cnt;
    logic [15:0] hard_err_cnt;

    int errors = 0;
    int checks = 0;
    logic [3:0] exp_q[$];

    chan_link_sequencer #(
        .RST_CYCLES(4),
        .UP_TIMEOUT(16),
        .MAX_RETRY (2)
    ) dut (
        .io_clk        (io_clk),
        .io_reset_n    (io_reset_n),
        .enable        (enable),
        .clr_counts    (clr_counts),
        .pll_not_locked(pll_not_locked),
        .lane_up       (lane_up),
        .channel_up    (channel_up),
        .hard_err      (hard_err),
        .soft_err      (soft_err),
        .gt_reset      (gt_reset),
        .aurora_reset  (aurora_reset),
        .link_ok       (link_ok),
        .link_fail     (link_fail),
        .state         (state),
        .retry_cnt     (retry_cnt),
        .soft_err_cnt  (soft_err_cnt),
        .hard_err_cnt  (hard_err_cnt)
    );

    // Clock
    initial begin
        io_clk = 1'b0;
        forever #5 io_clk = ~io_clk;
    end

    // Advance one cycle; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge io_clk);
        #1;
    endtask

    task automatic init_inputs();
        enable         = 1'b0;
        clr_counts     = 1'b0;
        pll_not_locked = 1'b1;
        lane_up        = 1'b0;
        channel_up     = 1'b0;
        hard_err       = 1'b0;
        soft_err       = 1'b0;
    endtask

    task automatic do_reset();
        init_inputs();
        io_reset_n = 1'b0;
        tick();
        tick();
        io_reset_n = 1'b1;
    endtask

    // Bounded wait for a state code; an expired budget is recorded as a failure.
    task automatic wait_state(input logic [2:0] s, input string tag);
        int k;
        k = 0;
        while (state !== s && k < 100) begin
            tick();
            k++;
        end
        checks++;
        if (state !== s) begin
            errors++;
            $display("FAIL %s wait_state: got %0d expected %0d", tag, state, s);
        end
    endtask

    // Bring the link from reset to UP with PLL locked immediately.
    task automatic go_up(input string tag);
        do_reset();
        pll_not_locked = 1'b0;
        enable = 1'b1;
        wait_state(3'd3, tag);
        channel_up = 1'b1;
        lane_up    = 1'b1;
        tick();
        checks++;
        if (state !== 3'd4) begin
            errors++;
            $display("FAIL %s reach_up: got %0d expected 4", tag, state);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({state, gt_reset, aurora_reset, link_ok, link_fail} !== {3'd0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs: got st=%0d gt=%b au=%b ok=%b fl=%b expected st=0 gt=1 au=1 ok=0 fl=0",
                     state, gt_reset, aurora_reset, link_ok, link_fail);
        end
        checks++;
        if ({retry_cnt, soft_err_cnt, hard_err_cnt} !== 36'd0) begin
            errors++;
            $display("FAIL reset_counts: got r=%0d s=%0d h=%0d expected 0 0 0", retry_cnt, soft_err_cnt, hard_err_cnt);
        end
        tick();
        checks++;
        if (state !== 3'd0) begin
            errors++;
            $display("FAIL idle_hold: got %0d expected 0", state);
        end
    endtask

    task automatic test_nominal();
        int n;
        do_reset();
        enable = 1'b1;
        tick();
        checks++;
        if (state !== 3'd1) begin
            errors++;
            $display("FAIL nom_enter_reset: got %0d expected 1", state);
        end
        n = 0;
        while (gt_reset === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL nom_gt_reset_len: got %0d expected 4", n);
        end
        checks++;
        if ({state, aurora_reset} !== {3'd2, 1'b1}) begin
            errors++;
            $display("FAIL nom_wait_pll: got st=%0d au=%b expected st=2 au=1", state, aurora_reset);
        end
        tick();
        tick();
        checks++;
        if (state !== 3'd2) begin
            errors++;
            $display("FAIL nom_pll_hold: got %0d expected 2", state);
        end
        pll_not_locked = 1'b0;
        tick();
        checks++;
        if ({state, gt_reset, aurora_reset} !== {3'd3, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL nom_wait_up: got st=%0d gt=%b au=%b expected st=3 gt=0 au=0", state, gt_reset, aurora_reset);
        end
        for (int i = 0; i < 4; i++) tick();
        channel_up = 1'b1;
        lane_up    = 1'b1;
        tick();
        checks++;
        if ({state, link_ok, link_fail, retry_cnt} !== {3'd4, 1'b1, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL nom_up: got st=%0d ok=%b fl=%b r=%0d expected st=4 ok=1 fl=0 r=0",
                     state, link_ok, link_fail, retry_cnt);
        end
    endtask

    task automatic test_timeout();
        int n;
        logic [3:0] exp_r;
        do_reset();
        pll_not_locked = 1'b0;
        enable = 1'b1;
        exp_q.push_back(4'd1);
        exp_q.push_back(4'd2);
        exp_q.push_back(4'd2);
        for (int a = 0; a < 3; a++) begin
            wait_state(3'd3, "timeout");
            n = 0;
            while (state === 3'd3 && n < 40) begin
                tick();
                n++;
            end
            checks++;
            if (n !== 16) begin
                errors++;
                $display("FAIL to_wait_up_len[%0d]: got %0d expected 16", a, n);
            end
            exp_r = exp_q.pop_front();
            checks++;
            if (retry_cnt !== exp_r) begin
                errors++;
                $display("FAIL to_retry[%0d]: got %0d expected %0d", a, retry_cnt, exp_r);
            end
            checks++;
            if (state !== ((a < 2) ? 3'd1 : 3'd5)) begin
                errors++;
                $display("FAIL to_state[%0d]: got %0d expected %0d", a, state, (a < 2) ? 1 : 5);
            end
        end
        tick();
        tick();
        checks++;
        if ({state, link_fail, link_ok, gt_reset, aurora_reset} !== {3'd5, 1'b1, 1'b0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL to_fail_hold: got st=%0d fl=%b ok=%b gt=%b au=%b expected st=5 fl=1 ok=0 gt=1 au=1",
                     state, link_fail, link_ok, gt_reset, aurora_reset);
        end
        enable = 1'b0;
        tick();
        checks++;
        if ({state, retry_cnt, link_fail} !== {3'd0, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL to_disable: got st=%0d r=%0d fl=%b expected st=0 r=0 fl=0", state, retry_cnt, link_fail);
        end
    endtask

    task automatic test_drop_while_up();
        go_up("drop");
        soft_err = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        soft_err = 1'b0;
        hard_err = 1'b1;
        tick();
        hard_err = 1'b0;
        checks++;
        if ({soft_err_cnt, hard_err_cnt, retry_cnt, state} !== {16'd3, 16'd1, 4'd1, 3'd1}) begin
            errors++;
            $display("FAIL drop_result: got s=%0d h=%0d r=%0d st=%0d expected s=3 h=1 r=1 st=1",
                     soft_err_cnt, hard_err_cnt, retry_cnt, state);
        end
        clr_counts = 1'b1;
        tick();
        clr_counts = 1'b0;
        checks++;
        if ({retry_cnt, soft_err_cnt, hard_err_cnt, state} !== {4'd0, 16'd0, 16'd0, 3'd1}) begin
            errors++;
            $display("FAIL drop_clr: got r=%0d s=%0d h=%0d st=%0d expected r=0 s=0 h=0 st=1",
                     retry_cnt, soft_err_cnt, hard_err_cnt, state);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        pll_not_locked = 1'b0;
        enable = 1'b1;
        wait_state(3'd3, "simul");
        for (int i = 0; i < 15; i++) tick();
        checks++;
        if (state !== 3'd3) begin
            errors++;
            $display("FAIL sim_last_wait: got %0d expected 3", state);
        end
        channel_up = 1'b1;
        lane_up    = 1'b1;
        tick();
        checks++;
        if ({state, retry_cnt} !== {3'd4, 4'd0}) begin
            errors++;
            $display("FAIL sim_up_wins: got st=%0d r=%0d expected st=4 r=0", state, retry_cnt);
        end
        soft_err = 1'b1;
        tick();
        tick();
        checks++;
        if (soft_err_cnt !== 16'd2) begin
            errors++;
            $display("FAIL sim_soft_pre: got %0d expected 2", soft_err_cnt);
        end
        clr_counts = 1'b1;
        tick();
        clr_counts = 1'b0;
        soft_err   = 1'b0;
        checks++;
        if ({soft_err_cnt, state} !== {16'd0, 3'd4}) begin
            errors++;
            $display("FAIL sim_clr_priority: got s=%0d st=%0d expected s=0 st=4", soft_err_cnt, state);
        end
    endtask

    task automatic test_reset_mid_op();
        go_up("midrst");
        soft_err = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        soft_err = 1'b0;
        checks++;
        if (soft_err_cnt !== 16'd5) begin
            errors++;
            $display("FAIL mid_soft_pre: got %0d expected 5", soft_err_cnt);
        end
        io_reset_n = 1'b0;
        tick();
        io_reset_n = 1'b1;
        checks++;
        if ({state, gt_reset, aurora_reset, link_ok, link_fail, retry_cnt, soft_err_cnt, hard_err_cnt} !==
            {3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 16'd0, 16'd0}) begin
            errors++;
            $display("FAIL mid_reset_vals: got st=%0d gt=%b au=%b ok=%b fl=%b r=%0d s=%0d h=%0d expected 0 1 1 0 0 0 0 0",
                     state, gt_reset, aurora_reset, link_ok, link_fail, retry_cnt, soft_err_cnt, hard_err_cnt);
        end
        tick();
        tick();
        checks++;
        if ({state, gt_reset} !== {3'd1, 1'b1}) begin
            errors++;
            $display("FAIL mid_restart: got st=%0d gt=%b expected st=1 gt=1", state, gt_reset);
        end
    endtask

    task automatic test_saturation();
        go_up("sat");
        soft_err = 1'b1;
        for (int i = 0; i < 65534; i++) tick();
        checks++;
        if (soft_err_cnt !== 16'hFFFE) begin
            errors++;
            $display("FAIL sat_before: got %0h expected fffe", soft_err_cnt);
        end
        tick();
        checks++;
        if (soft_err_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_reach: got %0h expected ffff", soft_err_cnt);
        end
        for (int i = 0; i < 4465; i++) tick();
        soft_err = 1'b0;
        checks++;
        if ({soft_err_cnt, hard_err_cnt, state} !== {16'hFFFF, 16'd0, 3'd4}) begin
            errors++;
            $display("FAIL sat_hold: got s=%0h h=%0h st=%0d expected s=ffff h=0 st=4", soft_err_cnt, hard_err_cnt, state);
        end
    endtask

    // Test sequence and final report
    initial begin
        io_reset_n = 1'b0;
        init_inputs();
        test_reset();
        test_nominal();
        test_timeout();
        test_drop_while_up();
        test_simultaneous();
        test_reset_mid_op();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/chan_link_sequencer.md
CHAN_LINK_SEQUENCER -- requirements
Module: chan_link_sequencer

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 128, the number of io_clk cycles gt_reset is held per attempt (range 1..2^24-1).
REQ-002 SHALL have parameter UP_TIMEOUT, default 1000000, the cycle budget for WAIT_PLL and for WAIT_UP (range 1..2^24-1).
REQ-003 SHALL have parameter MAX_RETRY, default 7, the number of re-attempts before FAIL (range 0..15).
REQ-004 SHALL have ports:
- io_clk  in  1  the single clock
- io_reset_n  in  1  synchronous, active-low reset
- enable  in  1  level; 1 = bring the link up and keep it up
- clr_counts  in  1  one-cycle pulse that clears retry_cnt, soft_err_cnt and hard_err_cnt
- pll_not_locked  in  1  Aurora PLL status
- lane_up  in  1  Aurora lane status
- channel_up  in  1  Aurora channel status
- hard_err  in  1  Aurora error level
- soft_err  in  1  Aurora error level
- gt_reset  out  1  transceiver reset, active-high
- aurora_reset  out  1  Aurora core reset, active-high
- link_ok  out  1  1 only in state UP
- link_fail  out  1  1 only in state FAIL
- state  out  3  current state code
- retry_cnt  out  4  attempts used since the count was last cleared
- soft_err_cnt  out  16  soft_err cycles counted while UP
- hard_err_cnt  out  16  hard_err cycles counted while UP

Function
REQ-005 SHALL register every output; each output changes one cycle after the input or timer event that causes the change.
REQ-006 SHALL implement these states and codes: IDLE=0, RESET=1, WAIT_PLL=2, WAIT_UP=3, UP=4, FAIL=5; codes 6-7 SHALL go to IDLE on the next cycle.
REQ-007 SHALL hold gt_reset=1 in IDLE, RESET and FAIL, and gt_reset=0 in all other states.
REQ-008 SHALL hold aurora_reset=1 in IDLE, RESET, WAIT_PLL and FAIL, and aurora_reset=0 in WAIT_UP and UP.
REQ-009 IDLE SHALL leave for RESET when enable=1, loading a 24-bit down-timer with RST_CYCLES-1.
REQ-010 RESET SHALL decrement the timer each cycle, so that it lasts exactly RST_CYCLES cycles.
- At timer=0: go to WAIT_PLL and load UP_TIMEOUT-1.
REQ-011 WAIT_PLL SHALL go to WAIT_UP when pll_not_locked=0, reloading UP_TIMEOUT-1.
- If the timer reaches 0 while pll_not_locked=1: go to RETRY-DECISION.
REQ-012 WAIT_UP SHALL go to UP when channel_up=1 and lane_up=1 in the same cycle.
- If the timer reaches 0 first: go to RETRY-DECISION.
- If the up-condition and timer=0 coincide, UP wins.
REQ-013 UP SHALL go to RETRY-DECISION when hard_err=1, channel_up=0 or lane_up=0.
REQ-014 RETRY-DECISION is not a state; it is evaluated in the transition cycle:
- retry_cnt==MAX_RETRY: go to FAIL.
- Otherwise: increment retry_cnt and go to RESET with the timer loaded to RST_CYCLES-1.
REQ-015 FAIL SHALL be held until enable=0.
REQ-016 enable=0 SHALL force IDLE on the next cycle from any state, with priority over all other transitions.
- retry_cnt is cleared on entry to IDLE.
REQ-017 soft_err_cnt and hard_err_cnt SHALL each increment by 1 per cycle in which the state is UP and the respective input is 1.
- Both counters saturate at 16'hFFFF.
- The hard_err cycle that causes UP to exit is counted.
REQ-018 clr_counts SHALL zero all three counters on the next cycle, with priority over a simultaneous increment; the state is not affected.
- retry_cnt may be cleared mid-sequence; the next RETRY-DECISION uses the cleared value.

Reset
REQ-019 While io_reset_n=0 at a rising edge of io_clk, the block SHALL take:
- state=IDLE
- gt_reset=1, aurora_reset=1
- link_ok=0, link_fail=0
- all counters and the timer 0
REQ-020 Reset SHALL take effect from any state, including mid-RESET or UP; after release the block SHALL restart from IDLE per REQ-009.

Verification (RST_CYCLES=4, UP_TIMEOUT=16, MAX_RETRY=2)
REQ-021 Nominal bring-up:
- Stimulus: enable=1; pll_not_locked drops 3 cycles into WAIT_PLL; channel_up and lane_up rise 5 cycles into WAIT_UP.
- Response: gt_reset high exactly 4 cycles after IDLE exit; link_ok=1 one cycle after up; retry_cnt=0.
REQ-022 Timeout exhaustion:
- Stimulus: channel_up held 0.
- Response: WAIT_UP lasts 16 cycles per attempt; retry_cnt goes 1 then 2; then state=5 and link_fail=1, gt_reset=1 and aurora_reset=1.
- Then enable=0: state=0 and retry_cnt=0 next cycle.
REQ-023 Drop while UP:
- Stimulus: in UP, soft_err high 3 cycles, then a 1-cycle hard_err.
- Response: soft_err_cnt=3, hard_err_cnt=1, retry_cnt=1, state=1 on the next cycle.
REQ-024 Simultaneous events:
- Stimulus: channel_up and lane_up rise in the timer=0 cycle of WAIT_UP.
- Response: state=4, no retry.
- Stimulus: clr_counts coincident with soft_err in UP.
- Response: soft_err_cnt=0.
REQ-025 Reset mid-operation:
- Stimulus: io_reset_n=0 for 1 cycle during UP with soft_err_cnt=5.
- Response: all outputs at REQ-019 values; with enable still 1, state=1 two cycles after release.
REQ-026 Saturation:
- Stimulus: soft_err held high in UP for 70000 cycles.
- Response: soft_err_cnt=16'hFFFF, no wrap.
